// File: rtl/ex_result_stage.sv
// Purpose: execute-to-memory pipeline register; resolves branches, overflow traps, sticky flags, overflow count.
// Latency: one cycle from accept to out_valid; back-to-back accepts sustain one instruction per cycle.
// Backpressure: in_ready = !out_valid | out_ready; held outputs stay frozen while out_ready is low.
module ex_result_stage #(
    parameter int DATA_W    = 32,
    parameter int OVF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W+2:0]     alu_result,
    input  logic [4:0]            rd_addr,
    input  logic                  wb_en,
    input  logic                  flag_wr,
    input  logic                  trap_en,
    input  logic [2:0]            br_cond,
    input  logic [DATA_W-1:0]     br_target,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [4:0]            out_rd,
    output logic                  out_wb_en,
    output logic                  br_taken,
    output logic [DATA_W-1:0]     br_addr,
    output logic                  ovf_trap,
    output logic [2:0]            flags,
    output logic [OVF_CNT_W-1:0]  ovf_count
);

    // Everything the memory stage sees for one instruction, held as one register.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [4:0]        rd;
        logic              wb_en;
        logic              br_taken;
        logic [DATA_W-1:0] br_addr;
        logic              ovf_trap;
    } res_t;

    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_NE     = 3'b010;
    localparam logic [2:0] BR_ABOVE  = 3'b011;
    localparam logic [2:0] BR_NABOVE = 3'b100;
    localparam logic [2:0] BR_OVF    = 3'b101;
    localparam logic [2:0] BR_ALWAYS = 3'b110;

    res_t                 res_q, res_d;
    logic                 out_valid_q, out_valid_d;
    logic [2:0]           flags_q, flags_d;
    logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic                 in_ovf, in_eq, in_above;
    logic [DATA_W-1:0]    in_value;
    logic                 accept;
    logic                 cond_met;
    logic                 trap_hit;

    assign {in_ovf, in_eq, in_above, in_value} = alu_result;

    // A slot opens when the register is empty or its contents leave this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign trap_hit = trap_en && in_ovf;

    // Branch outcome from the incoming flags; the sticky register is never consulted here.
    always_comb begin
        cond_met = 1'b0;
        case (br_cond)
            BR_EQ:     cond_met = in_eq;
            BR_NE:     cond_met = !in_eq;
            BR_ABOVE:  cond_met = in_above;
            BR_NABOVE: cond_met = !in_above;
            BR_OVF:    cond_met = in_ovf;
            BR_ALWAYS: cond_met = 1'b1;
            default:   cond_met = 1'b0;
        endcase
    end

    // Next-state: flush wins, then accept (which also covers drain+accept), then drain.
    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        ovf_count_d = ovf_count_q;
        if (flush) begin
            out_valid_d    = 1'b0;
            res_d.br_taken = 1'b0;
            res_d.ovf_trap = 1'b0;
        end else if (accept) begin
            out_valid_d    = 1'b1;
            res_d.data     = in_value;
            res_d.rd       = rd_addr;
            res_d.br_addr  = br_target;
            // A trapping instruction must neither retire its write nor redirect fetch.
            res_d.ovf_trap = trap_hit;
            res_d.wb_en    = wb_en && !trap_hit;
            res_d.br_taken = cond_met && !trap_hit;
            if (flag_wr) begin
                flags_d = {in_ovf, in_eq, in_above};
            end
            if (in_ovf && (ovf_count_q != {OVF_CNT_W{1'b1}})) begin
                ovf_count_d = ovf_count_q + OVF_CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= 3'b000;
            ovf_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = res_q.data;
    assign out_rd    = res_q.rd;
    assign out_wb_en = res_q.wb_en;
    assign br_taken  = res_q.br_taken;
    assign br_addr   = res_q.br_addr;
    assign ovf_trap  = res_q.ovf_trap;
    assign flags     = flags_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Purpose: self-checking bench for ex_result_stage using an expected-result queue.
// Latency: expects each accepted beat on the outputs one cycle later.
// Backpressure: drives out_ready low/high to exercise hold, drain and drain+accept.
module tb_ex_result_stage;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wb_en;
        logic        taken;
        logic [31:0] addr;
        logic        trap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [34:0] alu_result;
    logic [4:0]  rd_addr;
    logic        wb_en;
    logic        flag_wr;
    logic        trap_en;
    logic [2:0]  br_cond;
    logic [31:0] br_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        ovf_trap;
    logic [2:0]  flags;
    logic [15:0] ovf_count;

    logic        s_in_ready, s_out_valid, s_out_wb_en, s_br_taken, s_ovf_trap;
    logic [31:0] s_out_data, s_br_addr;
    logic [4:0]  s_out_rd;
    logic [2:0]  s_flags;
    logic [1:0]  s_ovf_count;

    exp_t        obs;
    exp_t        head;
    exp_t        exp_q[$];
    logic [2:0]  exp_flags;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_sat;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign obs = '{data: out_data, rd: out_rd, wb_en: out_wb_en, taken: br_taken,
                   addr: br_addr, trap: ovf_trap};

    ex_result_stage #(.DATA_W(32), .OVF_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .rd_addr(rd_addr), .wb_en(wb_en), .flag_wr(flag_wr),
        .trap_en(trap_en), .br_cond(br_cond), .br_target(br_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .br_taken(br_taken), .br_addr(br_addr), .ovf_trap(ovf_trap),
        .flags(flags), .ovf_count(ovf_count)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    ex_result_stage #(.DATA_W(32), .OVF_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .alu_result(alu_result), .rd_addr(rd_addr), .wb_en(wb_en), .flag_wr(flag_wr),
        .trap_en(trap_en), .br_cond(br_cond), .br_target(br_target), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_rd(s_out_rd),
        .out_wb_en(s_out_wb_en), .br_taken(s_br_taken), .br_addr(s_br_addr), .ovf_trap(s_ovf_trap),
        .flags(s_flags), .ovf_count(s_ovf_count)
    );

    task automatic idle_inputs;
        in_valid   = 1'b0;
        alu_result = '0;
        rd_addr    = '0;
        wb_en      = 1'b0;
        flag_wr    = 1'b0;
        trap_en    = 1'b0;
        br_cond    = 3'b000;
        br_target  = '0;
        flush      = 1'b0;
    endtask

    task automatic reset_model;
        exp_q.delete();
        exp_flags = 3'b000;
        exp_cnt   = '0;
        exp_sat   = '0;
    endtask

    // Presents one beat; when acc is set the beat is expected to be taken at the next edge.
    task automatic drive(input logic ovf, input logic eq, input logic above,
                         input logic [31:0] val, input logic [4:0] rd, input logic wb,
                         input logic fw, input logic te, input logic [2:0] cond,
                         input logic [31:0] tgt, input bit acc);
        exp_t e;
        logic t;
        in_valid   = 1'b1;
        alu_result = {ovf, eq, above, val};
        rd_addr    = rd;
        wb_en      = wb;
        flag_wr    = fw;
        trap_en    = te;
        br_cond    = cond;
        br_target  = tgt;
        if (acc) begin
            case (cond)
                3'd1:    t = eq;
                3'd2:    t = !eq;
                3'd3:    t = above;
                3'd4:    t = !above;
                3'd5:    t = ovf;
                3'd6:    t = 1'b1;
                default: t = 1'b0;
            endcase
            e.data  = val;
            e.rd    = rd;
            e.addr  = tgt;
            e.trap  = te & ovf;
            e.wb_en = (te & ovf) ? 1'b0 : wb;
            e.taken = (te & ovf) ? 1'b0 : t;
            exp_q.push_back(e);
            if (fw) exp_flags = {ovf, eq, above};
            if (ovf) begin
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                if (exp_sat != 2'd3) exp_sat = exp_sat + 2'd1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL reset_fields: got %h want 0", obs); end
        n_cmp++;
        if ({out_valid, flags, ovf_count, s_ovf_count} !== '0) begin
            n_err++; $display("FAIL reset_state: got v=%b f=%b c=%h s=%h want 0", out_valid, flags, ovf_count, s_ovf_count);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL idle_after_reset: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_pass_through;
        out_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h5, 5'd3, 1'b1, 1'b0, 1'b0, 3'b001, 32'h40, 1'b1);
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid: got %b want 1", out_valid); end
        head = (exp_q.size() == 0) ? 'x : exp_q.pop_front();
        n_cmp++;
        if (obs !== head) begin n_err++; $display("FAIL pass_fields: got %h want %h", obs, head); end
        n_cmp++;
        if (out_data !== 32'h5 || out_rd !== 5'd3 || br_taken !== 1'b1 || br_addr !== 32'h40) begin
            n_err++; $display("FAIL pass_const: got d=%h rd=%0d t=%b a=%h want 5/3/1/40", out_data, out_rd, br_taken, br_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL pass_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_trap;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 3'b110, 32'h100, 1'b1);
        @(negedge clk);
        idle_inputs();
        head = (exp_q.size() == 0) ? 'x : exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== head) begin
            n_err++; $display("FAIL trap_fields: got v=%b %h want v=1 %h", out_valid, obs, head);
        end
        n_cmp++;
        if (ovf_trap !== 1'b1 || out_wb_en !== 1'b0 || br_taken !== 1'b0) begin
            n_err++; $display("FAIL trap_const: got trap=%b wb=%b t=%b want 1/0/0", ovf_trap, out_wb_en, br_taken);
        end
        n_cmp++;
        if (flags !== 3'b100 || ovf_count !== 16'd1 || s_ovf_count !== 2'd1) begin
            n_err++; $display("FAIL trap_state: got f=%b c=%0d s=%0d want 100/1/1", flags, ovf_count, s_ovf_count);
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 5'd9, 1'b1, 1'b0, 1'b0, 3'b011, 32'h200, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 5'd12, 1'b1, 1'b1, 1'b0, 3'b101, 32'h300, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== exp_q[0] || flags !== exp_flags) begin
                n_err++;
                $display("FAIL stall_hold%0d: got v=%b r=%b %h f=%b want v=1 r=0 %h f=%b",
                         i, out_valid, in_ready, obs, flags, exp_q[0], exp_flags);
            end
        end
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 5'd12, 1'b1, 1'b1, 1'b0, 3'b101, 32'h300, 1'b1);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", in_ready); end
        void'(exp_q.pop_front());
        @(negedge clk);
        idle_inputs();
        head = (exp_q.size() == 0) ? 'x : exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== head || flags !== exp_flags || ovf_count !== exp_cnt) begin
            n_err++; $display("FAIL stall_second: got v=%b %h f=%b c=%0d want %h f=%b c=%0d",
                              out_valid, obs, flags, ovf_count, head, exp_flags, exp_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        logic [2:0]  f_before;
        logic [15:0] c_before;
        out_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h1234, 5'd4, 1'b1, 1'b1, 1'b0, 3'b001, 32'h500, 1'b1);
        @(negedge clk);
        head = (exp_q.size() == 0) ? 'x : exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== head) begin
            n_err++; $display("FAIL flush_setup: got v=%b %h want v=1 %h", out_valid, obs, head);
        end
        f_before = exp_flags;
        c_before = exp_cnt;
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_0000, 5'd8, 1'b1, 1'b1, 1'b1, 3'b110, 32'h600, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (out_valid !== 1'b0 || br_taken !== 1'b0 || ovf_trap !== 1'b0) begin
            n_err++; $display("FAIL flush_kill: got v=%b t=%b trap=%b want 0/0/0", out_valid, br_taken, ovf_trap);
        end
        n_cmp++;
        if (flags !== f_before || ovf_count !== c_before) begin
            n_err++; $display("FAIL flush_state: got f=%b c=%0d want f=%b c=%0d", flags, ovf_count, f_before, c_before);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_after: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] fl;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fl = 3'($urandom_range(0, 7));
            drive(fl[2], fl[1], fl[0], $urandom, 5'($urandom_range(0, 31)), 1'b1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'(i), $urandom, 1'b1);
            @(negedge clk);
            head = (exp_q.size() == 0) ? 'x : exp_q.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== head) begin
                n_err++; $display("FAIL b2b_%0d: got v=%b %h want v=1 %h", i, out_valid, obs, head);
            end
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || flags !== exp_flags || ovf_count !== exp_cnt || s_ovf_count !== exp_sat) begin
            n_err++; $display("FAIL b2b_end: got v=%b f=%b c=%0d s=%0d want v=0 f=%b c=%0d s=%0d",
                              out_valid, flags, ovf_count, s_ovf_count, exp_flags, exp_cnt, exp_sat);
        end
    endtask

    task automatic test_saturation;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(i), 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 1'b1);
            @(negedge clk);
            void'(exp_q.pop_front());
            n_cmp++;
            if (s_ovf_count !== ((i < 3) ? 2'(i + 1) : 2'd3) || ovf_count !== 16'(i + 1)) begin
                n_err++; $display("FAIL sat_%0d: got s=%0d c=%0d want s=%0d c=%0d",
                                  i, s_ovf_count, ovf_count, (i < 3) ? i + 1 : 3, i + 1);
            end
        end
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (s_ovf_count !== 2'd3 || s_ovf_count !== exp_sat) begin
            n_err++; $display("FAIL sat_hold: got %0d want 3", s_ovf_count);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'hCAFE_0000, 5'd30, 1'b1, 1'b1, 1'b0, 3'b110, 32'h700, 1'b1);
        @(negedge clk);
        idle_inputs();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_setup: got %b want 1", out_valid); end
        rst = 1'b1;
        @(negedge clk);
        reset_model();
        n_cmp++;
        if (out_valid !== 1'b0 || obs !== '0 || flags !== 3'b000 || ovf_count !== 16'd0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rmid_clear: got v=%b %h f=%b c=%0d r=%b want all 0, r=1",
                              out_valid, obs, flags, ovf_count, in_ready);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_pulse: got %b want 0", out_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass_through();
        test_trap();
        test_stall();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
